// File: rtl/vortex_mem_rsp_buffer.sv
// ----------------------------------------------------------------------------
// vortex_mem_rsp_buffer
//
// Purpose:
//   Sits between a Vortex memory port and a memory slave that cannot stall its
//   responses. Requests pass straight through. Read responses are captured in
//   a small circular FIFO so that Vortex can apply backpressure on the
//   response channel. A credit scheme stops reads from being issued unless a
//   FIFO slot is already reserved for their response, so the FIFO never
//   overflows. Writes carry no response and never consume credit.
//
// Ports:
//   clk, nRST                  clock (rising edge), async active-low reset
//   vx_req_*  (in)             Vortex request; rw=1 is a write
//   vx_req_ready (out)         request accepted when high with vx_req_valid
//   vx_rsp_valid/data/tag      head of the response FIFO
//   vx_rsp_ready (in)          Vortex pops the head
//   sl_req_* (out)             request forwarded to the slave
//   sl_req_ready (in)          slave accepts the request
//   sl_rsp_valid/data/tag (in) slave response, cannot be stalled
//   sl_rsp_ready (out)         tied high
//   outstanding (out)          reads accepted but not yet answered by slave
//   busy (out)                 reads in flight or responses queued
//   err_unexpected_rsp (out)   sticky: slave answered with nothing in flight
// ----------------------------------------------------------------------------
module vortex_mem_rsp_buffer #(
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 512,
    parameter int TAG_W     = 56,
    parameter int RSP_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic                    vx_req_valid,
    input  logic                    vx_req_rw,
    input  logic [DATA_W/8-1:0]     vx_req_byteen,
    input  logic [ADDR_W-1:0]       vx_req_addr,
    input  logic [DATA_W-1:0]       vx_req_data,
    input  logic [TAG_W-1:0]        vx_req_tag,
    output logic                    vx_req_ready,
    output logic                    vx_rsp_valid,
    output logic [DATA_W-1:0]       vx_rsp_data,
    output logic [TAG_W-1:0]        vx_rsp_tag,
    input  logic                    vx_rsp_ready,
    output logic                    sl_req_valid,
    output logic                    sl_req_rw,
    output logic [DATA_W/8-1:0]     sl_req_byteen,
    output logic [ADDR_W-1:0]       sl_req_addr,
    output logic [DATA_W-1:0]       sl_req_data,
    output logic [TAG_W-1:0]        sl_req_tag,
    input  logic                    sl_req_ready,
    input  logic                    sl_rsp_valid,
    input  logic [DATA_W-1:0]       sl_rsp_data,
    input  logic [TAG_W-1:0]        sl_rsp_tag,
    output logic                    sl_rsp_ready,
    output logic [$clog2(RSP_DEPTH):0] outstanding,
    output logic                    busy,
    output logic                    err_unexpected_rsp
);

    localparam int PW = $clog2(RSP_DEPTH);   // pointer width
    localparam int CW = PW + 1;              // counter width (0..RSP_DEPTH)
    localparam int EW = DATA_W + TAG_W;      // FIFO entry width

    localparam logic [PW-1:0] LP_PTR_ZERO  = PW'(0);
    localparam logic [PW-1:0] LP_PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] LP_CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] LP_CNT_ONE   = CW'(1);
    localparam logic [CW:0]   LP_DEPTH_EXT = (CW + 1)'(RSP_DEPTH);
    localparam logic [EW-1:0] LP_ENTRY_ZERO = EW'(0);

    // Registered state
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_fifo_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_err;
    logic [EW-1:0] r_mem [RSP_DEPTH];

    // Combinational helpers
    logic          w_credit_ok;
    logic          w_rd_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_unexpected;
    logic [CW-1:0] w_outstanding_nxt;
    logic [CW-1:0] w_fifo_count_nxt;
    logic [EW-1:0] w_head;

    // Request path is a pure pass-through; only valid/ready are gated by credit.
    assign sl_req_rw     = vx_req_rw;
    assign sl_req_byteen = vx_req_byteen;
    assign sl_req_addr   = vx_req_addr;
    assign sl_req_data   = vx_req_data;
    assign sl_req_tag    = vx_req_tag;

    // Every in-flight read owns a FIFO slot, so reads are blocked as soon as
    // in-flight plus queued responses would exceed the FIFO capacity.
    assign w_credit_ok  = ({1'b0, r_outstanding} + {1'b0, r_fifo_count}) < LP_DEPTH_EXT;
    assign sl_req_valid = vx_req_valid & (vx_req_rw | w_credit_ok);
    assign vx_req_ready = sl_req_ready & (vx_req_rw | w_credit_ok);

    assign w_rd_accept  = vx_req_valid & vx_req_ready & ~vx_req_rw;
    assign w_push       = sl_rsp_valid & (r_outstanding != LP_CNT_ZERO);
    assign w_unexpected = sl_rsp_valid & (r_outstanding == LP_CNT_ZERO);
    assign w_pop        = (r_fifo_count != LP_CNT_ZERO) & vx_rsp_ready;

    // Slave responses are never stalled.
    assign sl_rsp_ready = 1'b1;

    // Response head comes straight from registered storage (no bypass).
    assign w_head       = r_mem[r_rd_ptr];
    assign vx_rsp_valid = (r_fifo_count != LP_CNT_ZERO);
    assign vx_rsp_data  = w_head[EW-1:TAG_W];
    assign vx_rsp_tag   = w_head[TAG_W-1:0];

    assign outstanding        = r_outstanding;
    assign err_unexpected_rsp = r_err;
    assign busy               = (r_outstanding != LP_CNT_ZERO) | (r_fifo_count != LP_CNT_ZERO);

    // Next-state for the in-flight read counter; accept and response together cancel.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        case ({w_rd_accept, w_push})
            2'b10:   w_outstanding_nxt = r_outstanding + LP_CNT_ONE;
            2'b01:   w_outstanding_nxt = r_outstanding - LP_CNT_ONE;
            default: w_outstanding_nxt = r_outstanding;
        endcase
    end

    // Next-state for the FIFO occupancy; push and pop together cancel.
    always_comb begin
        w_fifo_count_nxt = r_fifo_count;
        case ({w_push, w_pop})
            2'b10:   w_fifo_count_nxt = r_fifo_count + LP_CNT_ONE;
            2'b01:   w_fifo_count_nxt = r_fifo_count - LP_CNT_ONE;
            default: w_fifo_count_nxt = r_fifo_count;
        endcase
    end

    // Counters, pointers and the sticky error flag.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_outstanding <= LP_CNT_ZERO;
            r_fifo_count  <= LP_CNT_ZERO;
            r_wr_ptr      <= LP_PTR_ZERO;
            r_rd_ptr      <= LP_PTR_ZERO;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_fifo_count  <= w_fifo_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            if (w_unexpected) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Response storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= LP_ENTRY_ZERO;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {sl_rsp_data, sl_rsp_tag};
            end else begin
                r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
            end
        end
    end

    vortex_mem_rsp_buffer_chk #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_chk (
        .clk          (clk),
        .nRST         (nRST),
        .i_push       (w_push),
        .i_fifo_count (r_fifo_count),
        .i_outstanding(r_outstanding)
    );

endmodule

// ----------------------------------------------------------------------------
// vortex_mem_rsp_buffer_chk
//
// Purpose:
//   Implementation assertions for the response buffer: the credit rule must
//   keep pushes away from a full FIFO and keep in-flight plus queued
//   responses within the FIFO capacity.
//
// Ports:
//   clk, nRST       clock and async active-low reset
//   i_push          FIFO push this cycle
//   i_fifo_count    current FIFO occupancy
//   i_outstanding   current in-flight read count
// ----------------------------------------------------------------------------
module vortex_mem_rsp_buffer_chk #(
    parameter int RSP_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        nRST,
    input  logic                        i_push,
    input  logic [$clog2(RSP_DEPTH):0]  i_fifo_count,
    input  logic [$clog2(RSP_DEPTH):0]  i_outstanding
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0] LP_DEPTH     = CW'(RSP_DEPTH);
    localparam logic [CW:0]   LP_DEPTH_EXT = (CW + 1)'(RSP_DEPTH);

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!nRST)
        !(i_push && (i_fifo_count == LP_DEPTH))
    );

    a_credit_bound: assert property (
        @(posedge clk) disable iff (!nRST)
        (({1'b0, i_outstanding} + {1'b0, i_fifo_count}) <= LP_DEPTH_EXT)
    );

endmodule

// File: tb/tb_vortex_mem_rsp_buffer.sv
module tb_vortex_mem_rsp_buffer;

    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 512;
    localparam int TAG_W     = 56;
    localparam int RSP_DEPTH = 4;

    logic                 clk;
    logic                 nRST;
    logic                 vx_req_valid;
    logic                 vx_req_rw;
    logic [DATA_W/8-1:0]  vx_req_byteen;
    logic [ADDR_W-1:0]    vx_req_addr;
    logic [DATA_W-1:0]    vx_req_data;
    logic [TAG_W-1:0]     vx_req_tag;
    logic                 vx_req_ready;
    logic                 vx_rsp_valid;
    logic [DATA_W-1:0]    vx_rsp_data;
    logic [TAG_W-1:0]     vx_rsp_tag;
    logic                 vx_rsp_ready;
    logic                 sl_req_valid;
    logic                 sl_req_rw;
    logic [DATA_W/8-1:0]  sl_req_byteen;
    logic [ADDR_W-1:0]    sl_req_addr;
    logic [DATA_W-1:0]    sl_req_data;
    logic [TAG_W-1:0]     sl_req_tag;
    logic                 sl_req_ready;
    logic                 sl_rsp_valid;
    logic [DATA_W-1:0]    sl_rsp_data;
    logic [TAG_W-1:0]     sl_rsp_tag;
    logic                 sl_rsp_ready;
    logic [$clog2(RSP_DEPTH):0] outstanding;
    logic                 busy;
    logic                 err_unexpected_rsp;

    int n_checks = 0;
    int n_pass   = 0;

    vortex_mem_rsp_buffer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk                (clk),
        .nRST               (nRST),
        .vx_req_valid       (vx_req_valid),
        .vx_req_rw          (vx_req_rw),
        .vx_req_byteen      (vx_req_byteen),
        .vx_req_addr        (vx_req_addr),
        .vx_req_data        (vx_req_data),
        .vx_req_tag         (vx_req_tag),
        .vx_req_ready       (vx_req_ready),
        .vx_rsp_valid       (vx_rsp_valid),
        .vx_rsp_data        (vx_rsp_data),
        .vx_rsp_tag         (vx_rsp_tag),
        .vx_rsp_ready       (vx_rsp_ready),
        .sl_req_valid       (sl_req_valid),
        .sl_req_rw          (sl_req_rw),
        .sl_req_byteen      (sl_req_byteen),
        .sl_req_addr        (sl_req_addr),
        .sl_req_data        (sl_req_data),
        .sl_req_tag         (sl_req_tag),
        .sl_req_ready       (sl_req_ready),
        .sl_rsp_valid       (sl_rsp_valid),
        .sl_rsp_data        (sl_rsp_data),
        .sl_rsp_tag         (sl_rsp_tag),
        .sl_rsp_ready       (sl_rsp_ready),
        .outstanding        (outstanding),
        .busy               (busy),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic rw, input logic [63:0] tag);
        vx_req_valid = v;
        vx_req_rw    = rw;
        vx_req_tag   = TAG_W'(tag);
        vx_req_addr  = ADDR_W'(tag);
        vx_req_data  = DATA_W'(tag);
    endtask

    task automatic drive_rsp(input logic v, input logic [63:0] tag, input logic [63:0] data);
        sl_rsp_valid = v;
        sl_rsp_tag   = TAG_W'(tag);
        sl_rsp_data  = DATA_W'(data);
    endtask

    initial begin
        int acc;
        int n;
        nRST          = 1'b0;
        vx_req_byteen = '1;
        vx_rsp_ready  = 1'b0;
        sl_req_ready  = 1'b1;
        drive_req(1'b0, 1'b0, 64'd0);
        drive_rsp(1'b0, 64'd0, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_rsp_valid",   64'(vx_rsp_valid), 64'd0);
        chk("rst_busy",        64'(busy), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err",         64'(err_unexpected_rsp), 64'd0);
        chk("rst_rsp_data",    vx_rsp_data[63:0], 64'd0);
        chk("rst_rsp_tag",     64'(vx_rsp_tag), 64'd0);
        chk("rst_sl_rsp_ready", 64'(sl_rsp_ready), 64'd1);
        nRST = 1'b1;
        step();

        // Single read, slave answers one cycle later
        vx_req_valid = 1'b1;
        vx_req_rw    = 1'b0;
        vx_req_addr  = ADDR_W'(26'h100);
        vx_req_tag   = TAG_W'(56'h2A);
        #1;
        chk("rd_req_ready",  64'(vx_req_ready), 64'd1);
        chk("rd_sl_valid",   64'(sl_req_valid), 64'd1);
        chk("rd_sl_addr",    64'(sl_req_addr), 64'h100);
        chk("rd_sl_tag",     64'(sl_req_tag), 64'h2A);
        step();
        vx_req_valid = 1'b0;
        drive_rsp(1'b1, 64'h2A, 64'hDEAD);
        #1;
        chk("rd_out_c1",     64'(outstanding), 64'd1);
        chk("rd_novalid_c1", 64'(vx_rsp_valid), 64'd0);
        step();
        drive_rsp(1'b0, 64'd0, 64'd0);
        #1;
        chk("rd_valid_c2",   64'(vx_rsp_valid), 64'd1);
        chk("rd_data_c2",    vx_rsp_data[63:0], 64'hDEAD);
        chk("rd_tag_c2",     64'(vx_rsp_tag), 64'h2A);
        chk("rd_out_c2",     64'(outstanding), 64'd0);
        chk("rd_busy_c2",    64'(busy), 64'd1);
        vx_rsp_ready = 1'b1;
        step();
        vx_rsp_ready = 1'b0;
        #1;
        chk("rd_popped_valid", 64'(vx_rsp_valid), 64'd0);
        chk("rd_popped_busy",  64'(busy), 64'd0);

        // Backpressure fill: six reads, only four fit
        acc = 0;
        for (int i = 1; i <= 6; i++) begin
            drive_req(1'b1, 1'b0, 64'(i));
            #1;
            if (vx_req_ready) acc++;
            step();
        end
        chk("fill_accepted", 64'(acc), 64'd4);
        chk("fill_out",      64'(outstanding), 64'd4);
        chk("fill_rd_blocked", 64'(vx_req_ready), 64'd0);
        chk("fill_sl_valid_blocked", 64'(sl_req_valid), 64'd0);
        vx_req_rw = 1'b1;
        #1;
        chk("fill_wr_ready", 64'(vx_req_ready), 64'd1);
        chk("fill_wr_sl_valid", 64'(sl_req_valid), 64'd1);
        step();
        vx_req_valid = 1'b0;
        vx_req_rw    = 1'b0;
        #1;
        chk("fill_wr_no_credit", 64'(outstanding), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            drive_rsp(1'b1, 64'(i), 64'(i * 17));
            step();
        end
        drive_rsp(1'b0, 64'd0, 64'd0);
        vx_req_valid = 1'b1;
        #1;
        chk("full_out",        64'(outstanding), 64'd0);
        chk("full_valid",      64'(vx_rsp_valid), 64'd1);
        chk("full_rd_blocked", 64'(vx_req_ready), 64'd0);
        chk("full_head_tag",   64'(vx_rsp_tag), 64'd1);
        step();
        vx_req_valid = 1'b0;
        #1;
        chk("hold_head_tag",  64'(vx_rsp_tag), 64'd1);
        chk("hold_head_data", vx_rsp_data[63:0], 64'd17);

        // Drain in order
        vx_rsp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("drain_valid_%0d", i), 64'(vx_rsp_valid), 64'd1);
            chk($sformatf("drain_tag_%0d", i),   64'(vx_rsp_tag), 64'(i));
            chk($sformatf("drain_data_%0d", i),  vx_rsp_data[63:0], 64'(i * 17));
            step();
        end
        chk("drain_empty", 64'(vx_rsp_valid), 64'd0);

        // Back-to-back stream across pointer wrap: count stays at 1, one response per cycle
        n = 6;
        for (int c = 0; c <= n + 1; c++) begin
            drive_req(c < n, 1'b0, 64'(32 + c));
            if ((c >= 1) && (c <= n)) begin
                drive_rsp(1'b1, 64'(32 + c - 1), 64'((32 + c - 1) * 3));
            end else begin
                drive_rsp(1'b0, 64'd0, 64'd0);
            end
            #1;
            if (c < n) chk($sformatf("strm_ready_%0d", c), 64'(vx_req_ready), 64'd1);
            if ((c >= 1) && (c < n)) chk($sformatf("strm_out_%0d", c), 64'(outstanding), 64'd1);
            if (c >= 2) begin
                chk($sformatf("strm_valid_%0d", c), 64'(vx_rsp_valid), 64'd1);
                chk($sformatf("strm_tag_%0d", c),   64'(vx_rsp_tag), 64'(32 + c - 2));
                chk($sformatf("strm_data_%0d", c),  vx_rsp_data[63:0], 64'((32 + c - 2) * 3));
            end
            step();
        end
        chk("strm_empty", 64'(vx_rsp_valid), 64'd0);
        chk("strm_idle",  64'(busy), 64'd0);

        // Unexpected response with nothing in flight
        drive_rsp(1'b1, 64'h77, 64'h1234);
        step();
        drive_rsp(1'b0, 64'd0, 64'd0);
        #1;
        chk("unexp_err",   64'(err_unexpected_rsp), 64'd1);
        chk("unexp_valid", 64'(vx_rsp_valid), 64'd0);
        step();
        chk("unexp_sticky", 64'(err_unexpected_rsp), 64'd1);
        chk("unexp_still_empty", 64'(vx_rsp_valid), 64'd0);

        // Reset mid-operation: three queued, one in flight
        vx_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 1'b0, 64'(64 + i));
            step();
        end
        vx_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rsp(1'b1, 64'(64 + i), 64'(64 + i));
            step();
        end
        drive_rsp(1'b0, 64'd0, 64'd0);
        #1;
        chk("pre_rst_valid", 64'(vx_rsp_valid), 64'd1);
        chk("pre_rst_out",   64'(outstanding), 64'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(vx_rsp_valid), 64'd0);
        chk("mid_rst_out",   64'(outstanding), 64'd0);
        chk("mid_rst_busy",  64'(busy), 64'd0);
        chk("mid_rst_err",   64'(err_unexpected_rsp), 64'd0);
        chk("mid_rst_tag",   64'(vx_rsp_tag), 64'd0);
        chk("mid_rst_data",  vx_rsp_data[63:0], 64'd0);
        step();
        nRST = 1'b1;
        drive_rsp(1'b1, 64'h55, 64'h55);
        step();
        drive_rsp(1'b0, 64'd0, 64'd0);
        #1;
        chk("post_rst_err",   64'(err_unexpected_rsp), 64'd1);
        chk("post_rst_valid", 64'(vx_rsp_valid), 64'd0);
        chk("post_rst_out",   64'(outstanding), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
